// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider: 50%-duty clk_out plus a one-cycle tick on every edge.
// Define CLKDIV_TICKCNT_EN to add the wrapping tick_cnt output.
`timescale 1ns/1ps

module clkdiv_prog #(
    parameter int CNT_W   = 25,
    parameter int DIV_RST = 50
`ifdef CLKDIV_TICKCNT_EN
    ,
    parameter int TCNT_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
`ifdef CLKDIV_TICKCNT_EN
    ,
    output logic [TCNT_W-1:0] tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(DIV_RST);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] shadow;
    logic             halted;
    logic             wrap;

    // ratio-1 is evaluated in CNT_W bits; ratio==0 is excluded by halted.
    assign halted = !en || (ratio == '0);
    assign wrap   = !halted && (cnt == ratio - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ratio   <= RST_VAL;
            shadow  <= RST_VAL;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else if (sync_clr) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (div_load) begin
                ratio  <= div_val;
                shadow <= div_val;
            end else if (pending) begin
                ratio <= shadow;
            end
        end else if (halted) begin
            // No phase in progress to protect: a waiting shadow applies now,
            // while a load arriving this cycle waits for the next edge.
            tick <= 1'b0;
            if (pending) begin
                ratio <= shadow;
            end
            if (div_load) begin
                shadow <= div_val;
            end
            pending <= div_load;
        end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
            pending <= 1'b0;
            if (div_load) begin
                ratio  <= div_val;
                shadow <= div_val;
            end else if (pending) begin
                ratio <= shadow;
            end
        end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
            if (div_load) begin
                shadow  <= div_val;
                pending <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_TICKCNT_EN
    // Counts the same edges that raise tick; sync_clr deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!sync_clr && wrap) begin
            tick_cnt <= tick_cnt + TCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: directed scenarios pinned by literals, then random
// stimulus compared every cycle against a phase-elapsed behavioural model.
`timescale 1ns/1ps

module tb_clkdiv_prog;

    localparam int CW = 25;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sync_clr;
    logic          div_load;
    logic [CW-1:0] div_val;
    logic          clk_out;
    logic          tick;
    logic          pending;
`ifdef CLKDIV_TICKCNT_EN
    logic [TW-1:0] tick_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // model: elapsed cycles in current phase, active/shadow ratio, outputs
    int m_ph, m_h, m_sh, m_tc;
    bit m_pend, m_out, m_tick;

    clkdiv_prog #(
        .CNT_W   (CW),
        .DIV_RST (50)
`ifdef CLKDIV_TICKCNT_EN
        ,
        .TCNT_W  (TW)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .div_load (div_load),
        .div_val  (div_val),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
`ifdef CLKDIV_TICKCNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_h = 50; m_sh = 50; m_tc = 0;
        m_pend = 0; m_out = 0; m_tick = 0;
    endtask

    task automatic model_step();
        int v;
        v = int'(div_val);
        if (!rst_n) begin
            model_reset();
        end else if (sync_clr) begin
            if (div_load) begin m_h = v; m_sh = v; end
            else if (m_pend) m_h = m_sh;
            m_pend = 0; m_ph = 0; m_out = 0; m_tick = 0;
        end else if (!en || m_h == 0) begin
            m_tick = 0;
            if (m_pend) m_h = m_sh;
            if (div_load) m_sh = v;
            m_pend = div_load;
        end else if (m_ph + 1 == m_h) begin
            m_ph = 0; m_out = !m_out; m_tick = 1;
            m_tc = (m_tc + 1) % (1 << TW);
            if (div_load) begin m_h = v; m_sh = v; end
            else if (m_pend) m_h = m_sh;
            m_pend = 0;
        end else begin
            m_ph++; m_tick = 0;
            if (div_load) begin m_sh = v; m_pend = 1; end
        end
    endtask

    task automatic compare();
        chk("clk_out", int'(clk_out), int'(m_out));
        chk("tick", int'(tick), int'(m_tick));
        chk("pending", int'(pending), int'(m_pend));
`ifdef CLKDIV_TICKCNT_EN
        chk("tick_cnt", int'(tick_cnt), m_tc);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int t0;
        bit v;
        rst_n = 0; en = 1; sync_clr = 0; div_load = 0; div_val = '0;
        model_reset();
        #12;
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_pending", int'(pending), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // defaults: edges at 50 and 100
        for (int c = 1; c <= 100; c++) begin
            step();
            if (c == 49) chk("t1_tick49", int'(tick), 0);
            if (c == 50) begin chk("t1_tick50", int'(tick), 1); chk("t1_rise50", int'(clk_out), 1); end
            if (c == 51) chk("t1_tick51", int'(tick), 0);
            if (c == 100) begin chk("t1_tick100", int'(tick), 1); chk("t1_fall100", int'(clk_out), 0); end
        end

        // load 3 at cnt=10; current 50-cycle phase completes
        steps(10);
        div_load = 1; div_val = 3;
        step();
        div_load = 0;
        chk("t2_pending", int'(pending), 1);
        steps(38);
        chk("t2_no_trunc", int'(tick), 0);
        step();
        chk("t2_tick150", int'(tick), 1);
        chk("t2_pend_clr", int'(pending), 0);
        chk("t2_clk150", int'(clk_out), 1);
        steps(3);
        chk("t2_tick153", int'(tick), 1);
        chk("t2_clk153", int'(clk_out), 0);
        steps(3);
        chk("t2_clk156", int'(clk_out), 1);

        // H=1 then H=0 freeze
        div_load = 1; div_val = 1;
        step();
        div_load = 0;
        steps(2);
        chk("t3_h1_first", int'(tick), 1);
        v = clk_out;
        for (int i = 0; i < 6; i++) begin
            step();
            v = !v;
            chk("t3_h1_tick", int'(tick), 1);
            chk("t3_h1_toggle", int'(clk_out), int'(v));
        end
        div_load = 1; div_val = 0;
        step();
        div_load = 0;
        step();
        chk("t3_frz_tick", int'(tick), 0);
        v = clk_out;
        steps(3);
        chk("t3_frz_clk", int'(clk_out), int'(v));
        chk("t3_frz_tick2", int'(tick), 0);

        // restore 50 while halted, then en=0 for 7 cycles at cnt=20
        div_load = 1; div_val = 50;
        step();
        div_load = 0;
        chk("t4_pend_halt", int'(pending), 1);
        step();
        chk("t4_applied", int'(pending), 0);
        steps(20);
        en = 0;
        steps(7);
        chk("t4_hold_tick", int'(tick), 0);
        en = 1;
        steps(29);
        chk("t4_tick29", int'(tick), 0);
        step();
        chk("t4_tick30", int'(tick), 1);

        // sync_clr with simultaneous load of 4
        steps(5);
        sync_clr = 1; div_load = 1; div_val = 4;
        step();
        sync_clr = 0; div_load = 0;
        chk("t5_clk", int'(clk_out), 0);
        chk("t5_tick", int'(tick), 0);
        chk("t5_pend", int'(pending), 0);
        steps(3);
        chk("t5_tick3", int'(tick), 0);
        step();
        chk("t5_tick4", int'(tick), 1);
        chk("t5_clk4", int'(clk_out), 1);

`ifdef CLKDIV_TICKCNT_EN
        sync_clr = 1; div_load = 1; div_val = 2;
        step();
        sync_clr = 0; div_load = 0;
        t0 = m_tc;
        steps(32);
        chk("t6_wrap16", int'(tick_cnt), t0);
`else
        t0 = 0;
`endif
        // async reset mid-phase
        step();
        rst_n = 0;
        #1;
        chk("t6_rst_clk", int'(clk_out), 0);
        chk("t6_rst_tick", int'(tick), 0);
        chk("t6_rst_pend", int'(pending), 0);
`ifdef CLKDIV_TICKCNT_EN
        chk("t6_rst_tcnt", int'(tick_cnt), 0);
`endif
        step();
        rst_n = 1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom % 8) != 0;
            sync_clr = ($urandom % 60) == 0;
            div_load = ($urandom % 12) == 0;
            div_val  = CW'($urandom % 10);
            step();
        end
        en = 1; sync_clr = 0; div_load = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
